johnson_seq_ctrl: RTL
=====================

Name: johnson_seq_ctrl

Overview:
- Controller and sequencer for a parameterised Johnson (twisted-ring) counter.
- Accepts a step count, a direction and an optional seed.
- Steps the ring exactly N times, then reports completion; supports abort.
- Checks every seed and every ring value for illegal (non-Johnson) codes and recovers to all-zeros.
- Sits between a command source (CPU regs / test FSM) and logic consuming multi-phase enables.

Parameters:
- WIDTH, 4, ring width in bits (>=2); full period is 2*WIDTH states.
- CNT_W, 8, width of step-count field; max run length 2^CNT_W-1 steps.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; honoured only in IDLE.
- stop  input  1  abort request; honoured in RUN; in IDLE it blocks start.
- dir  input  1  0 = shift right (msb<=~lsb), 1 = shift left (lsb<=~msb); latched on start.
- len  input  CNT_W  number of steps for the run; latched on start.
- seed_we  input  1  write seed into ring; honoured only in IDLE.
- seed  input  WIDTH  ring value to load.
- dout  output  WIDTH  current ring value.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse after the final step of a completed run.
- aborted  output  1  one-cycle pulse when a run is terminated by stop.
- err  output  1  sticky illegal-code flag; cleared only by reset.

Behaviour:
- Reset (sync, dominant over all inputs):
  - dout=0, state=IDLE, busy=0, done=0, aborted=0, err=0.
  - Latched len, dir and remaining counter are cleared.
- States: IDLE, RUN, DONE.
  - IDLE + start & !stop & len!=0 -> RUN. Latch dir; remaining<=len. dout is not changed on this edge.
  - IDLE + start & !stop & len==0 -> DONE. No step.
  - IDLE + start & stop -> stay IDLE. stop wins; no pulse.
  - RUN, each cycle without stop: dout steps once and remaining decrements. When remaining==1 the step is taken and the next state is DONE.
  - RUN + stop -> IDLE. No step that edge; dout holds; aborted=1 next cycle; done not asserted.
  - DONE -> IDLE unconditionally. done=1 for exactly this cycle.
- Step rules:
  - dir=0: dout <= {~dout[0], dout[WIDTH-1:1]}.
  - dir=1: dout <= {dout[WIDTH-2:0], ~dout[WIDTH-1]}.
  - Wrap-around is natural: the sequence repeats every 2*WIDTH steps.
- Timing:
  - busy is high for exactly len cycles.
  - done is high in the cycle after the last step.
  - start is ignored in RUN and DONE.
  - Latency from start edge to done = len+1 cycles.
- Seed:
  - seed_we in IDLE loads dout<=seed on the next edge. It is ignored in RUN and DONE.
  - If seed_we and start occur in the same IDLE cycle, seed loads and start is ignored.
- Legality check:
  - t = popcount(v ^ {v[0], v[WIDTH-1:1]}). v is legal iff t is 0 or 2.
  - It is applied to seed on seed_we and to dout every cycle in RUN.
  - Illegal seed: dout<=0 instead of seed; err<=1.
  - Illegal dout in RUN: next dout<=0 instead of the step; err<=1; the run continues and remaining still decrements.
- Reset mid-run: returns to IDLE with dout=0. No done or aborted pulse.
- Step arithmetic: remaining is CNT_W bits, unsigned, never underflows because it is only decremented while non-zero.

Decomposition:
- Shared package johnson_pkg holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - direction constants (DIR_RIGHT=0, DIR_LEFT=1);
  - a function johnson_legal(v) returning the legality bit.
- Sub-module johnson_core(WIDTH) holds the ring register. It has:
  - inputs step, dir, load, load_val;
  - synchronous clear;
  - output dout.
- The controller owns the FSM, the remaining counter, the pulses and err.

Test Plan:
- Reset, then start, dir=0, len=5 from 0000 -> dout steps 1000,1100,1110,1111,0111; busy high 5 cycles; done one cycle later; final dout=0111.
- Start, dir=0, len=8 from 0000 -> dout returns to 0000 (full period); done=1 once; err=0.
- Start, dir=1, len=3 from 0000 -> 0001,0011,0111; done pulse.
- Start, len=10, dir=0; assert stop after 3 steps -> dout holds 1110; busy drops; aborted pulse; no done. Then start with len=1 -> dout=1111, done.
- seed_we with seed=1010 in IDLE -> dout=0000, err=1 and stays 1. seed_we with seed=1100 -> dout=1100, err still 1. Reset -> err=0.
- Start with len=0 -> done the next cycle, busy never high, dout unchanged. Reset asserted mid-run (len=6, after 2 steps) -> dout=0000, busy=0, no done/aborted.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared encodings and the Johnson-code legality test for the ring sequencer.
package johnson_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   localparam int LEGAL_MAX_W = 64;

   // A Johnson code has at most one 0->1 and one 1->0 boundary around the ring,
   // so comparing each bit with its rotated neighbour yields 0 or 2 differences.
   function automatic logic johnson_legal(input logic [LEGAL_MAX_W-1:0] v, input int w);
      logic [LEGAL_MAX_W-1:0] mask;
      logic [LEGAL_MAX_W-1:0] rot;
      int t;
      mask = {LEGAL_MAX_W{1'b1}} >> (LEGAL_MAX_W - w);
      rot  = (v >> 1) | ({{(LEGAL_MAX_W-1){1'b0}}, v[0]} << (w - 1));
      t    = $countones((v ^ rot) & mask);
      return (t == 0) || (t == 2);
   endfunction

endpackage

// File: rtl/johnson_core.sv
// Johnson ring register: clear beats load, load beats step; one step per enabled edge.
module johnson_core
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             step,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] dout
);

   always_ff @(posedge clk) begin
      if (clear) begin
         dout <= '0;
      end else if (load) begin
         dout <= load_val;
      end else if (step) begin
         if (dir == DIR_LEFT) begin
            dout <= {dout[WIDTH-2:0], ~dout[WIDTH-1]};
         end else begin
            dout <= {~dout[0], dout[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Runs a Johnson ring for a latched number of steps, then pulses done; stop aborts.
// Start-to-done latency is len+1 cycles; illegal seeds/ring codes force zero and set sticky err.
module johnson_seq_ctrl
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             dir,
   input  logic [CNT_W-1:0] len,
   input  logic             seed_we,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             err
);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] remaining;
   logic             dir_q;
   logic             aborted_q;
   logic             err_q;
   logic [WIDTH-1:0] ring;
   logic             ring_step;
   logic             ring_load;
   logic [WIDTH-1:0] ring_load_val;
   logic             err_set;
   logic             seed_ok;
   logic             ring_ok;
   logic             start_ok;

   assign seed_ok  = johnson_legal(LEGAL_MAX_W'(seed), WIDTH);
   assign ring_ok  = johnson_legal(LEGAL_MAX_W'(ring), WIDTH);
   // A seed write in the same cycle takes the slot, and stop in IDLE vetoes start.
   assign start_ok = start && !stop && !seed_we;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_ok) begin
               state_nxt = (len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (remaining == CNT_W'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state == RUN);
      done    = (state == DONE);
      aborted = aborted_q;
      err     = err_q;
      dout    = ring;
   end

   always_comb begin
      ring_step     = 1'b0;
      ring_load     = 1'b0;
      ring_load_val = '0;
      err_set       = 1'b0;
      if (state == IDLE && seed_we) begin
         ring_load = 1'b1;
         if (seed_ok) begin
            ring_load_val = seed;
         end else begin
            err_set = 1'b1;
         end
      end else if (state == RUN) begin
         err_set = !ring_ok;
         if (!stop) begin
            ring_step = ring_ok;
            ring_load = !ring_ok;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         remaining <= '0;
         dir_q     <= DIR_RIGHT;
         aborted_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         aborted_q <= (state == RUN) && stop;
         if (err_set) begin
            err_q <= 1'b1;
         end
         if (state == IDLE && start_ok) begin
            remaining <= len;
            dir_q     <= dir;
         end else if (state == RUN && !stop) begin
            remaining <= remaining - CNT_W'(1);
         end
      end
   end

   johnson_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk      (clk),
      .clear    (reset),
      .step     (ring_step),
      .dir      (dir_q),
      .load     (ring_load),
      .load_val (ring_load_val),
      .dout     (ring)
   );

endmodule
